// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative MIPS mult/multu/div/divu engine with HI/LO registers
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_N,
    input  logic             Start,
    input  logic [2:0]       MD_Op,
    input  logic [WIDTH-1:0] In_1,
    input  logic [WIDTH-1:0] In_2,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_is_div;
    logic                   r_div0;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_is_mul;
    logic                   w_is_div;
    logic                   w_signed;
    logic                   w_neg1;
    logic                   w_neg2;
    logic [WIDTH-1:0]       w_mag1;
    logic [WIDTH-1:0]       w_mag2;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH:0]         w_rem_sh;
    logic                   w_ge;
    logic [WIDTH-1:0]       w_diff;
    logic [2*WIDTH-1:0]     w_div_next;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;

    // ------------------------------------------------------------------
    // Request decode and operand magnitudes
    // ------------------------------------------------------------------
    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = w_ready && Start && !Flush;
    assign w_is_mul = (MD_Op == c_OP_MULT) || (MD_Op == c_OP_MULTU);
    assign w_is_div = (MD_Op == c_OP_DIV)  || (MD_Op == c_OP_DIVU);
    assign w_signed = (MD_Op == c_OP_MULT) || (MD_Op == c_OP_DIV);
    assign w_neg1   = w_signed && In_1[WIDTH-1];
    assign w_neg2   = w_signed && In_2[WIDTH-1];
    assign w_mag1   = w_neg1 ? (~In_1 + 1'b1) : In_1;
    assign w_mag2   = w_neg2 ? (~In_2 + 1'b1) : In_2;

    // Shift-add: upper half accumulates the partial product, lower half
    // holds the not-yet-consumed multiplier bits.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division: upper half is the partial remainder, lower half the
    // dividend being shifted out while quotient bits shift in.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_next = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_ge};

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                            : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
                if (w_accept && w_is_mul) begin
                    w_next = S_MUL;
                end else if (w_accept && w_is_div) begin
                    w_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (Flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = Flush ? S_IDLE : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_accept && w_is_mul) begin
                r_a      <= w_mag1;
                r_b      <= w_mag2;
                r_acc    <= {{WIDTH{1'b0}}, w_mag2};
                r_cnt    <= '0;
                r_neg_q  <= w_neg1 ^ w_neg2;
                r_neg_r  <= w_neg1;
                r_is_div <= 1'b0;
                r_div0   <= 1'b0;
            end else if (w_accept && w_is_div) begin
                // Raw dividend kept for the divide-by-zero result.
                r_a      <= In_1;
                r_b      <= w_mag2;
                r_acc    <= {{WIDTH{1'b0}}, w_mag1};
                r_cnt    <= '0;
                r_neg_q  <= w_neg1 ^ w_neg2;
                r_neg_r  <= w_neg1;
                r_is_div <= 1'b1;
                r_div0   <= (In_2 == '0);
            end else if (w_accept && (MD_Op == c_OP_MTHI)) begin
                r_hi <= In_1;
            end else if (w_accept && (MD_Op == c_OP_MTLO)) begin
                r_lo <= In_1;
            end

            if (r_state == S_MUL) begin
                r_acc <= w_mul_next;
                r_cnt <= r_cnt + c_CNT_ONE;
            end else if (r_state == S_DIV) begin
                r_acc <= w_div_next;
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if ((r_state == S_FIX) && !Flush) begin
                if (!r_is_div) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else if (r_div0) begin
                    r_hi <= r_a;
                    r_lo <= {WIDTH{1'b1}};
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign Busy = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    assign Done = (r_state == S_DONE);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : scoreboard bench for mul_div_unit (WIDTH=32 and WIDTH=8)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  in1_8;
    logic [7:0]  in2_8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) u_dut (
        .Clk(clk), .Rst_N(rst_n), .Start(start), .MD_Op(op),
        .In_1(in1), .In_2(in2), .Flush(flush),
        .Busy(busy), .Done(done), .HI(hi), .LO(lo)
    );

    mul_div_unit #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Rst_N(rst_n), .Start(start8), .MD_Op(op8),
        .In_1(in1_8), .In_2(in2_8), .Flush(1'b0),
        .Busy(busy8), .Done(done8), .HI(hi8), .LO(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {HI, LO} from native SV arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            c_OP_MULT:  return sa * sb;
            c_OP_MULTU: return {32'd0, a} * {32'd0, b};
            c_OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            c_OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        sb_q.push_back(model(o, a, b));
    endtask

    task automatic wait_done(input int glitch_at);
        int          n;
        int          nb;
        bit          seen;
        logic [63:0] e;
        n    = 0;
        nb   = 0;
        seen = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            n = i;
            if (busy) nb++;
            if (glitch_at != 0 && i == glitch_at) begin
                start = 1'b1;
                op    = c_OP_MTHI;
                in1   = 32'hDEAD_BEEF;
            end
            if (glitch_at != 0 && i == glitch_at + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(n), 64'd34);
        check("busy_cycles", 64'(nb), 64'd33);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : {64{1'bx}};
        check("hi", 64'(hi), 64'(e[63:32]));
        check("lo", 64'(lo), 64'(e[31:0]));
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_at);
        @(negedge clk);
        start_op(o, a, b);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(glitch_at);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          nb8;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        in1    = '0;
        in2    = '0;
        flush  = 1'b0;
        start8 = 1'b0;
        op8    = 3'd0;
        in1_8  = '0;
        in2_8  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = c_OP_MTHI; in1 = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_busy", 64'(busy), 64'd0);
        op = c_OP_MTLO; in1 = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        check("mtlo_hi", 64'(hi), 64'h1234_5678);
        check("mtlo_done", 64'(done), 64'd0);

        // DIV flushed at iteration 10
        @(negedge clk);
        start = 1'b1; op = c_OP_DIV; in1 = 32'd100; in2 = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("flush_no_done", 64'(cnt), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234_5678);
        check("flush_lo", 64'(lo), 64'h9ABC_DEF0);

        // Flush in IDLE suppresses a simultaneous Start
        @(negedge clk);
        start = 1'b1; op = c_OP_MTHI; in1 = 32'hFFFF_0000; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("idle_flush_hi", 64'(hi), 64'h1234_5678);

        run(c_OP_MULT, 32'hFFFF_FFFD, 32'd5, 5);
        check("mult_const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFF1);
        run(c_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        // Back-to-back: Start on the Done cycle
        start_op(c_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0);
        run(c_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(c_OP_DIVU, 32'd100, 32'd0, 0);

        // Reset during MUL iteration 5
        @(negedge clk);
        start = 1'b1; op = c_OP_MULT; in1 = 32'd7; in2 = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 2 == 1) rb = rb & 32'h0000_000F;
            run(rop, ra, rb, 0);
        end

        // WIDTH=8 instance: MULT 0x80 * 0x80
        @(negedge clk);
        start8 = 1'b1; op8 = c_OP_MULT; in1_8 = 8'h80; in2_8 = 8'h80;
        @(posedge clk);
        #1 start8 = 1'b0;
        cnt = 0;
        nb8 = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            cnt = i;
            if (busy8) nb8++;
            if (done8) break;
        end
        check("w8_latency", 64'(cnt), 64'd10);
        check("w8_busy_cycles", 64'(nb8), 64'd9);
        check("w8_hi", 64'(hi8), 64'h40);
        check("w8_lo", 64'(lo8), 64'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
